// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin (or fixed-priority) grant, one operation in flight,
// registered ALU operands, and a registered valid/ready response tagged
// with the requester ID.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic [CTRL_W-1:0] r0_ctr,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,
    output logic              r0_gnt,
    input  logic              r1_req,
    input  logic [CTRL_W-1:0] r1_ctr,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,
    output logic              r1_gnt,
    output logic [WIDTH-1:0]  alu_busA,
    output logic [WIDTH-1:0]  alu_busB,
    output logic [CTRL_W-1:0] alu_ctr,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_over,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_over,
    output logic              rsp_err
);

    localparam logic [CTRL_W-1:0] OP_ADD = '0;
    localparam logic [CTRL_W-1:0] OP_MAX = CTRL_W'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last;      // requester granted most recently
    logic   cur_id;    // requester owning the op in flight
    logic   gnt_any;
    logic   gnt_r1;
    logic   op_err;

    // Grant decision: only in IDLE and never while reset is asserted
    always_comb begin
        gnt_any = 1'b0;
        gnt_r1  = 1'b0;
        if (rst_n && (state == IDLE)) begin
            gnt_any = r0_req | r1_req;
            if (r0_req && r1_req) begin
                gnt_r1 = RR ? ~last : 1'b0;
            end else begin
                gnt_r1 = r1_req;
            end
        end
    end

    assign r0_gnt = gnt_any & ~gnt_r1;
    assign r1_gnt = gnt_any &  gnt_r1;
    assign op_err = (alu_ctr > OP_MAX);

    // Operation FSM: issue operands, capture ALU result, hold response until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            cur_id    <= 1'b0;
            alu_busA  <= '0;
            alu_busB  <= '0;
            alu_ctr   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_over  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        alu_busA <= gnt_r1 ? r1_a   : r0_a;
                        alu_busB <= gnt_r1 ? r1_b   : r0_b;
                        alu_ctr  <= gnt_r1 ? r1_ctr : r0_ctr;
                        cur_id   <= gnt_r1;
                        last     <= gnt_r1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    rsp_data  <= op_err ? '0 : alu_out;
                    rsp_over  <= ~op_err & alu_over & (alu_ctr == OP_ADD);
                    rsp_err   <= op_err;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives a round-robin and a fixed-priority alu_arbiter
// from shared requesters, emulates the ALU for each, and compares every
// cycle against a transaction-level model (issue time + pending op).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r1_req, rsp_ready;
    logic [3:0]  r0_ctr, r1_ctr;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;

    // round-robin instance (x) and fixed-priority instance (y)
    logic        r0_gnt_x, r1_gnt_x, r0_gnt_y, r1_gnt_y;
    logic [31:0] alu_busA_x, alu_busB_x, alu_busA_y, alu_busB_y;
    logic [3:0]  alu_ctr_x, alu_ctr_y;
    logic [31:0] alu_out_x, alu_out_y;
    logic        alu_over_x, alu_over_y;
    logic        rsp_valid_x, rsp_valid_y, rsp_id_x, rsp_id_y;
    logic [31:0] rsp_data_x, rsp_data_y;
    logic        rsp_over_x, rsp_over_y, rsp_err_x, rsp_err_y;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    // ALU behaviour: {overflow, result}; undefined opcodes return junk on purpose
    function automatic logic [32:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        r = '0;
        o = 1'b0;
        case (c)
            4'd0: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a | b;
            4'd3: r = a & b;
            4'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin r = a ^ b; o = 1'b1; end
        endcase
        return {o, r};
    endfunction

    assign {alu_over_x, alu_out_x} = alu_f(alu_ctr_x, alu_busA_x, alu_busB_x);
    assign {alu_over_y, alu_out_y} = alu_f(alu_ctr_y, alu_busA_y, alu_busB_y);

    alu_arbiter #(.WIDTH(32), .CTRL_W(4), .RR(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_ctr(r0_ctr), .r0_a(r0_a), .r0_b(r0_b), .r0_gnt(r0_gnt_x),
        .r1_req(r1_req), .r1_ctr(r1_ctr), .r1_a(r1_a), .r1_b(r1_b), .r1_gnt(r1_gnt_x),
        .alu_busA(alu_busA_x), .alu_busB(alu_busB_x), .alu_ctr(alu_ctr_x),
        .alu_out(alu_out_x), .alu_over(alu_over_x),
        .rsp_valid(rsp_valid_x), .rsp_ready(rsp_ready), .rsp_id(rsp_id_x),
        .rsp_data(rsp_data_x), .rsp_over(rsp_over_x), .rsp_err(rsp_err_x)
    );

    alu_arbiter #(.WIDTH(32), .CTRL_W(4), .RR(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_ctr(r0_ctr), .r0_a(r0_a), .r0_b(r0_b), .r0_gnt(r0_gnt_y),
        .r1_req(r1_req), .r1_ctr(r1_ctr), .r1_a(r1_a), .r1_b(r1_b), .r1_gnt(r1_gnt_y),
        .alu_busA(alu_busA_y), .alu_busB(alu_busB_y), .alu_ctr(alu_ctr_y),
        .alu_out(alu_out_y), .alu_over(alu_over_y),
        .rsp_valid(rsp_valid_y), .rsp_ready(rsp_ready), .rsp_id(rsp_id_y),
        .rsp_data(rsp_data_y), .rsp_over(rsp_over_y), .rsp_err(rsp_err_y)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model per instance: pending op with its issue cycle; response visible
    // from issue+2 until accepted; arbiter free whenever nothing is pending.
    logic        m_busy [2];
    int          m_issue[2];
    logic        m_id   [2];
    logic [3:0]  m_c    [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic        m_last [2];

    task automatic cmp_dut(input int d, input string t,
                           input logic g0, input logic g1,
                           input logic [31:0] ba, input logic [31:0] bb, input logic [3:0] bc,
                           input logic rv, input logic ri, input logic [31:0] rd,
                           input logic ro, input logic re);
        logic        ev, win, any, eg0, eg1, e_err;
        logic [32:0] res;
        if (!rst_n) begin
            chk({t, ".rst_gnt"}, {g0, g1}, 2'b00);
            chk({t, ".rst_bus"}, {ba, bb, bc}, '0);
            chk({t, ".rst_rsp"}, {rv, ri, rd, ro, re}, '0);
            m_busy[d] = 1'b0;
            m_last[d] = 1'b1;
            m_c[d] = '0; m_a[d] = '0; m_b[d] = '0; m_id[d] = 1'b0;
            return;
        end
        ev  = m_busy[d] && (cyc - m_issue[d] >= 2);
        any = !m_busy[d] && (r0_req || r1_req);
        if (r0_req && r1_req) win = (d == 0) ? !m_last[d] : 1'b0;
        else                  win = r1_req;
        eg0 = any && !win;
        eg1 = any && win;
        chk({t, ".gnt"}, {g0, g1}, {eg0, eg1});
        chk({t, ".bus"}, {ba, bb, bc}, {m_a[d], m_b[d], m_c[d]});
        chk({t, ".rsp_valid"}, rv, ev);
        if (ev) begin
            res   = alu_f(m_c[d], m_a[d], m_b[d]);
            e_err = (m_c[d] > 4'd4);
            chk({t, ".rsp_id"}, ri, m_id[d]);
            chk({t, ".rsp_data"}, rd, e_err ? 32'd0 : res[31:0]);
            chk({t, ".rsp_over"}, ro, (m_c[d] == 4'd0) ? res[32] : 1'b0);
            chk({t, ".rsp_err"}, re, e_err);
            if (rsp_ready) m_busy[d] = 1'b0;
        end
        if (any) begin
            m_busy[d]  = 1'b1;
            m_issue[d] = cyc;
            m_id[d]    = win;
            m_last[d]  = win;
            m_c[d]     = win ? r1_ctr : r0_ctr;
            m_a[d]     = win ? r1_a   : r0_a;
            m_b[d]     = win ? r1_b   : r0_b;
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        cmp_dut(0, "rr", r0_gnt_x, r1_gnt_x, alu_busA_x, alu_busB_x, alu_ctr_x,
                rsp_valid_x, rsp_id_x, rsp_data_x, rsp_over_x, rsp_err_x);
        cmp_dut(1, "fp", r0_gnt_y, r1_gnt_y, alu_busA_y, alu_busB_y, alu_ctr_y,
                rsp_valid_y, rsp_id_y, rsp_data_y, rsp_over_y, rsp_err_y);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from a requester on the round-robin instance and wait for its response
    task automatic do_op(input logic who, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int gw, output int lat,
                         output logic [31:0] d, output logic ov, output logic er, output logic id);
        if (who) begin r1_req = 1'b1; r1_ctr = c; r1_a = a; r1_b = b; end
        else     begin r0_req = 1'b1; r0_ctr = c; r0_a = a; r0_b = b; end
        #1;
        gw = 0;
        while (!(who ? r1_gnt_x : r0_gnt_x) && gw < 20) begin @(posedge clk); #2; gw++; end
        chk("grant_timeout", (gw < 20), 1'b1);
        @(posedge clk); #1;
        r0_req = 1'b0;
        r1_req = 1'b0;
        #1;
        lat = 1;
        while (!rsp_valid_x && lat < 20) begin @(posedge clk); #2; lat++; end
        d = rsp_data_x; ov = rsp_over_x; er = rsp_err_x; id = rsp_id_x;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gw, lat, nx, ny;
        logic [31:0] d;
        logic        ov, er, id;
        logic [3:0]  gx, gy;
        logic [31:0] edge_v [4];
        edge_v[0] = 32'h0; edge_v[1] = 32'h7FFF_FFFF; edge_v[2] = 32'h8000_0000; edge_v[3] = 32'hFFFF_FFFF;

        rst_n = 1'b0; rsp_ready = 1'b0;
        r0_req = 1'b0; r0_ctr = '0; r0_a = '0; r0_b = '0;
        r1_req = 1'b0; r1_ctr = '0; r1_a = '0; r1_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // r0 ADD 5+7 straight after reset
        rsp_ready = 1'b1;
        do_op(1'b0, 4'd0, 32'd5, 32'd7, gw, lat, d, ov, er, id);
        chk("t1_gnt_cycle", gw, 0);
        chk("t1_latency", lat, 2);
        chk("t1_data", d, 32'd12);
        chk("t1_id_over", {id, ov}, 2'b00);

        // r1 ADD overflow, then SUB with the same operands
        do_op(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, gw, lat, d, ov, er, id);
        chk("t2_add_data", d, 32'h8000_0000);
        chk("t2_add_id_over", {id, ov}, 2'b11);
        do_op(1'b1, 4'd1, 32'h7FFF_FFFF, 32'd1, gw, lat, d, ov, er, id);
        chk("t2_sub_data", d, 32'h7FFF_FFFE);
        chk("t2_sub_over", ov, 1'b0);

        // undefined opcode from r1, then a normal op
        do_op(1'b1, 4'hA, 32'd3, 32'd5, gw, lat, d, ov, er, id);
        chk("t5_err_rsp", {er, ov, id}, 3'b101);
        chk("t5_err_data", d, 32'd0);
        do_op(1'b0, 4'd2, 32'd3, 32'd5, gw, lat, d, ov, er, id);
        chk("t5_next_ok", {er, d}, {1'b0, 32'd7});

        // SLT under back-pressure; a waiting request must not be granted
        tick();
        rsp_ready = 1'b0;
        do_op(1'b0, 4'd4, 32'hFFFF_FFFF, 32'd1, gw, lat, d, ov, er, id);
        chk("t4_slt_data", d, 32'd1);
        r1_req = 1'b1; r1_ctr = 4'd0; r1_a = 32'd1; r1_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("t4_hold", {rsp_valid_x, rsp_data_x, r1_gnt_x}, {1'b1, 32'd1, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        chk("t4_gnt_after_accept", r1_gnt_x, 1'b1);
        @(posedge clk); #1;
        r1_req = 1'b0;
        repeat (3) tick();

        // both requesting continuously from a fresh reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        r0_req = 1'b1; r0_ctr = 4'd0; r0_a = 32'd10; r0_b = 32'd1;
        r1_req = 1'b1; r1_ctr = 4'd1; r1_a = 32'd10; r1_b = 32'd1;
        gx = '0; gy = '0; nx = 0; ny = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (r0_gnt_x || r1_gnt_x) begin gx = {gx[2:0], r1_gnt_x}; nx++; end
            if (r0_gnt_y || r1_gnt_y) begin gy = {gy[2:0], r1_gnt_y}; ny++; end
            tick();
        end
        chk("t3_rr_order", {nx[3:0], gx}, {4'd4, 4'b0101});
        chk("t3_fp_order", {ny[3:0], gy}, {4'd4, 4'b0000});
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (5) tick();

        // reset while an op is executing
        r0_req = 1'b1; r0_ctr = 4'd0; r0_a = 32'd1; r0_b = 32'd2;
        #1 chk("t6_gnt", r0_gnt_x, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {alu_busA_x, alu_busB_x, alu_ctr_x, r0_gnt_x, rsp_valid_x, rsp_data_x}, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        r1_req = 1'b1;
        #1 chk("t6_tie_after_reset", {r0_gnt_x, r1_gnt_x, rsp_valid_x}, 3'b100);
        tick();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            r0_req = ($urandom_range(0, 99) < 55);
            r1_req = ($urandom_range(0, 99) < 55);
            r0_ctr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            r1_ctr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            r0_a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            r0_b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            r1_a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            r1_b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        r0_req = 1'b0; r1_req = 1'b0; rsp_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
